// File: rtl/cdb_pkg.sv
// Shared widths, requester indices and helpers for the common data bus scheduler.
package cdb_pkg;

    localparam int unsigned N_REQ  = 3;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned ROB_W  = 2;
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam int unsigned REQ_LD   = 0;
    localparam int unsigned REQ_MULT = 1;
    localparam int unsigned REQ_ADD  = 2;

    // Index of the set bit in a one-hot requester vector (0 when empty).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_prio_pick.sv
// Lowest-index set bit of a vector, returned one-hot (zero in, zero out).
module cdb_prio_pick #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] pick
);

    // Two's-complement isolate of the lowest set bit.
    assign pick = vec & (~vec + N'(1));

endmodule

// File: rtl/cdb_scheduler.sv
// CDB owner: fixed-priority writeback grant, registered broadcast of the winning slice.
// Optional starvation relief via per-requester age counters when CDB_AGING_EN is defined.
module cdb_scheduler
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ   = cdb_pkg::N_REQ,
    parameter int unsigned DATA_W  = cdb_pkg::DATA_W,
    parameter int unsigned TAG_W   = cdb_pkg::TAG_W,
    parameter int unsigned ROB_W   = cdb_pkg::ROB_W,
    parameter int unsigned AGE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*ROB_W-1:0]  req_rob,
    output logic [N_REQ-1:0]        gnt,
    output logic                    cdb_valid,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [ROB_W-1:0]        cdb_rob,
    output logic [N_REQ-1:0]        cdb_src
);

    logic [N_REQ-1:0]  base_pick;
    logic [N_REQ-1:0]  gnt_sel;
    logic [N_REQ-1:0]  xfer;
    logic [DATA_W-1:0] mux_data;
    logic [TAG_W-1:0]  mux_tag;
    logic [ROB_W-1:0]  mux_rob;

    cdb_prio_pick #(.N(N_REQ)) u_base_pick (
        .vec  (req),
        .pick (base_pick)
    );

`ifdef CDB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] age [N_REQ];
    logic [N_REQ-1:0] aged_vec;
    logic [N_REQ-1:0] aged_pick;

    always_comb begin
        aged_vec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            aged_vec[i] = req[i] && (age[i] == AGE_W'(AGE_MAX));
        end
    end

    cdb_prio_pick #(.N(N_REQ)) u_aged_pick (
        .vec  (aged_vec),
        .pick (aged_pick)
    );

    assign gnt_sel = (|aged_pick) ? aged_pick : base_pick;

    // Waiting requesters count up to saturation; any grant, idle or flush clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req[i] && !gnt[i] && !flush) begin
                    if (age[i] != AGE_W'(AGE_MAX)) age[i] <= age[i] + AGE_W'(1);
                end else begin
                    age[i] <= '0;
                end
            end
        end
    end
`else
    assign gnt_sel = base_pick;
`endif

    assign gnt  = (rst_n && !flush) ? gnt_sel : '0;
    assign xfer = req & gnt;

    // One-hot AND-OR mux of the granted slice.
    always_comb begin
        mux_data = '0;
        mux_tag  = '0;
        mux_rob  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mux_data = mux_data | ({DATA_W{xfer[i]}} & req_data[i*DATA_W +: DATA_W]);
            mux_tag  = mux_tag  | ({TAG_W{xfer[i]}}  & req_tag[i*TAG_W +: TAG_W]);
            mux_rob  = mux_rob  | ({ROB_W{xfer[i]}}  & req_rob[i*ROB_W +: ROB_W]);
        end
    end

    // Broadcast registers: payload holds its last value between transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            cdb_rob   <= '0;
            cdb_src   <= '0;
        end else begin
            cdb_valid <= |xfer;
            if (|xfer) begin
                cdb_data <= mux_data;
                cdb_tag  <= mux_tag;
                cdb_rob  <= mux_rob;
                cdb_src  <= xfer;
            end
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Scoreboard bench for cdb_scheduler: driver queues expected broadcasts, monitor checks them.
module tb_cdb_scheduler;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 4;
    localparam int unsigned RW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic [RW-1:0] rob;
        logic [N-1:0]  src;
    } bcast_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    req = '0;
    logic [DW-1:0]   dv [N];
    logic [TW-1:0]   tv [N];
    logic [RW-1:0]   rv [N];
    logic [DW-1:0]   pd [N];
    logic [TW-1:0]   pt [N];
    logic [RW-1:0]   pr [N];
    logic [N*DW-1:0] req_data;
    logic [N*TW-1:0] req_tag;
    logic [N*RW-1:0] req_rob;
    logic [N-1:0]    gnt;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic [RW-1:0]   cdb_rob;
    logic [N-1:0]    cdb_src;

    int checks = 0;
    int failures = 0;
    bcast_t sbq[$];

    assign req_data = {dv[2], dv[1], dv[0]};
    assign req_tag  = {tv[2], tv[1], tv[0]};
    assign req_rob  = {rv[2], rv[1], rv[0]};

    cdb_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req       (req),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_rob   (req_rob),
        .gnt       (gnt),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_tag   (cdb_tag),
        .cdb_rob   (cdb_rob),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge, check gnt, queue the expected broadcast.
    task automatic step(input logic rn, input logic fl, input logic [N-1:0] rq,
                        input logic [N-1:0] exp_gnt, input string nm);
        bcast_t e;
        @(negedge clk);
        rst_n = rn;
        flush = fl;
        req   = rq;
        for (int i = 0; i < N; i++) begin
            dv[i] = pd[i];
            tv[i] = pt[i];
            rv[i] = pr[i];
        end
        #2;
        checks++;
        if (gnt !== exp_gnt) begin
            failures++;
            $display("FAIL gnt_%s: got %b expected %b", nm, gnt, exp_gnt);
        end
        if (exp_gnt != '0) begin
            for (int i = 0; i < N; i++) begin
                if (exp_gnt[i]) begin
                    e.data = pd[i];
                    e.tag  = pt[i];
                    e.rob  = pr[i];
                end
            end
            e.src = exp_gnt;
            sbq.push_back(e);
        end
    endtask

    task automatic check_idle(input string nm, input logic zero_payload);
        checks++;
        if (cdb_valid !== 1'b0 ||
            (zero_payload && {cdb_data, cdb_tag, cdb_rob, cdb_src} !== '0)) begin
            failures++;
            $display("FAIL idle_%s: got valid=%b data=%h tag=%h rob=%h src=%b expected valid=0",
                     nm, cdb_valid, cdb_data, cdb_tag, cdb_rob, cdb_src);
        end
    endtask

    // Entries queued one cycle earlier are due at this falling edge.
    always @(negedge clk) begin
        bcast_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (cdb_valid !== 1'b1 || {cdb_data, cdb_tag, cdb_rob, cdb_src} !== e) begin
                failures++;
                $display("FAIL bcast: got valid=%b data=%h tag=%h rob=%h src=%b expected valid=1 data=%h tag=%h rob=%h src=%b",
                         cdb_valid, cdb_data, cdb_tag, cdb_rob, cdb_src, e.data, e.tag, e.rob, e.src);
            end
        end else begin
            checks++;
            if (cdb_valid !== 1'b0) begin
                failures++;
                $display("FAIL no_bcast: got valid=%b src=%b expected valid=0", cdb_valid, cdb_src);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] contend [7];
        for (int i = 0; i < N; i++) begin
            pd[i] = '0; pt[i] = '0; pr[i] = '0;
            dv[i] = '0; tv[i] = '0; rv[i] = '0;
        end
`ifdef CDB_AGING_EN
        contend = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
`else
        contend = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif

        // Reset with every unit requesting
        step(1'b0, 1'b0, 3'b111, 3'b000, "rst0");
        step(1'b0, 1'b0, 3'b111, 3'b000, "rst1");
        check_idle("rst", 1'b1);

        // Single request from the adder
        pd[2] = 64'h1234; pt[2] = 4'd5; pr[2] = 2'd2;
        step(1'b1, 1'b0, 3'b100, 3'b100, "single");
        step(1'b1, 1'b0, 3'b000, 3'b000, "single_drop");
        step(1'b1, 1'b0, 3'b000, 3'b000, "single_idle");
        check_idle("single_after", 1'b0);

        // Back-to-back load results, tag 0 included
        pt[0] = 4'd0; pr[0] = 2'd1;
        for (int k = 1; k <= 3; k++) begin
            pd[0] = 64'(k);
            step(1'b1, 1'b0, 3'b001, 3'b001, "stream");
        end
        step(1'b1, 1'b0, 3'b000, 3'b000, "stream_idle");

        // Build up waiting age, then flush with a broadcast in flight
        pd[0] = 64'hAAAA_0000; pt[0] = 4'd1;  pr[0] = 2'd0;
        pd[1] = 64'hBBBB_1111; pt[1] = 4'd9;  pr[1] = 2'd3;
        pd[2] = 64'hCCCC_2222; pt[2] = 4'd15; pr[2] = 2'd1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'b111, 3'b001, "pre_flush");
        step(1'b1, 1'b1, 3'b011, 3'b000, "flush");
        step(1'b1, 1'b0, 3'b000, 3'b000, "post_flush");
        check_idle("post_flush", 1'b0);

        // Full contention from cleared ages
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 3'b111, contend[k], "contend");
        step(1'b1, 1'b0, 3'b000, 3'b000, "contend_idle");

        // Reset asserted while the multiplier is requesting
        pd[1] = 64'hDEAD_BEEF; pt[1] = 4'd7; pr[1] = 2'd2;
        step(1'b1, 1'b0, 3'b010, 3'b010, "mid_pre");
        step(1'b0, 1'b0, 3'b010, 3'b000, "mid_rst");
        step(1'b1, 1'b0, 3'b010, 3'b010, "mid_regrant");
        check_idle("mid_rst", 1'b1);
        step(1'b1, 1'b0, 3'b000, 3'b000, "mid_idle");
        step(1'b1, 1'b0, 3'b000, 3'b000, "drain");

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending broadcasts expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
